lsu_mem_initiator: RTL and testbench
====================================

# lsu_mem_initiator

Load/store initiator sitting between the MEM pipeline stage and the data memory. Accepts one load or store at a time from the core via a valid/ready handshake and checks size and alignment. Drives the memory's request lines (addr, write_data, memwrite, memread, sign_mask), follows the memory's clk_stall handshake to completion, and returns read data or an error cause as a single-cycle response pulse.

## Interface
Parameters:
- STALL_TIMEOUT, 16: maximum consecutive cycles with mem_clk_stall high in WAIT before aborting with a timeout error; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned: byte in [7:0], halfword in [15:0].
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  in  1  sign-extend loads; ignored for stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, already extended; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; 1 = request failed.
- resp_cause  out  2  when resp_err: 00 reserved size, 01 misaligned load, 10 misaligned store, 11 stall timeout.
- mem_addr  out  32  memory address.
- mem_write_data  out  32  memory write data; equals latched req_wdata, unshifted.
- mem_memwrite  out  1  memory write strobe.
- mem_memread  out  1  memory read strobe.
- mem_sign_mask  out  4  bit3 = signed; [2:0] = 001 byte, 011 halfword, 111 word.
- mem_read_data  in  32  registered memory read result.
- mem_clk_stall  in  1  memory busy; high while a write is in progress.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: req_ready=1; all mem strobes 0.
  - On req_valid, evaluate the request:
    - Reserved size: error cause 00.
    - Halfword with addr[0]=1, or word with addr[1:0]!=0: cause 01 (load) or 10 (store).
  - On error: latch the cause and go to RESP; no memory access is issued.
  - Otherwise: latch addr, wdata, write flag and sign_mask (bit3 = req_signed & ~req_write); go to ACCESS.
- ACCESS: exactly one cycle with mem_memread=~write or mem_memwrite=write; go to WAIT; clear stall counter.
- WAIT: strobes 0. mem_addr, mem_write_data and mem_sign_mask stay held, because the memory samples them combinationally through completion.
  - mem_clk_stall=1: increment counter; when counter reaches STALL_TIMEOUT, go to RESP with cause 11.
  - mem_clk_stall=0: for loads, capture mem_read_data into resp_rdata; go to RESP.
- RESP: resp_valid=1 for one cycle (no backpressure); go to IDLE. resp_rdata and resp_err hold until the next response.
- mem_addr, mem_write_data and mem_sign_mask hold their last values in IDLE; only the strobes qualify an access.
- Requests arriving while not IDLE are not accepted; the core holds them, as req_ready=0.

## Timing
- Reset values: req_ready=1 after the reset edge; resp_valid, resp_err, resp_cause, resp_rdata, mem_addr, mem_write_data, mem_memwrite, mem_memread and mem_sign_mask all 0; state IDLE.
- Load latency: accept edge at cycle 0, ACCESS cycle 1, WAIT cycle 2 with stall 0, resp_valid in cycle 3.
- Store latency:
  - Cycles 0-1 as for a load.
  - WAIT cycle 2: memory raises stall.
  - WAIT cycle 3: stall 0.
  - resp_valid in cycle 4.
  - Each extra stall cycle adds 1.
- Error latency: resp_valid in cycle 1 after accept; no strobe is asserted.
- Back-to-back throughput: the next accept occurs in the cycle after RESP; minimum 4 cycles per load and 5 per store.
- Timeout: in WAIT with stall continuously 1, resp_valid (cause 11) appears exactly STALL_TIMEOUT+1 cycles after entering WAIT.
- Reset mid-operation: rst_n low at any posedge forces IDLE and reset values; the aborted request produces no response. A write already strobed may still complete inside the memory, which is acceptable.
- Simultaneous req_valid and rst_n low: reset wins, request not accepted.

## Test plan
- Word load at 0x100 with memory word 0xDEADBEEF: mem_memread high for exactly 1 cycle, mem_sign_mask=0111; resp_valid in cycle 3 with resp_rdata=0xDEADBEEF, resp_err=0.
- Signed byte load at 0x103 with word 0x80FF_0000: mem_sign_mask=1001; resp_rdata=0xFFFFFF80.
- Halfword store of 0x1234 to 0x102, then word load at 0x100 of 0xAAAABBBB: store response in cycle 4 after mem_clk_stall high for 1 cycle; load returns 0x1234BBBB.
- Misaligned word load at 0x101: no strobe; resp_valid in cycle 1 with resp_err=1, resp_cause=01. Misaligned halfword store at 0x203: resp_cause=10. req_size=11: resp_cause=00.
- STALL_TIMEOUT=4 with mem_clk_stall forced high after a store: resp_err=1, resp_cause=11, resp_valid 5 cycles after WAIT entry; req_ready=1 on the next cycle.
- rst_n low during WAIT of a store: next cycle all outputs are at reset values, no resp_valid; a new load accepted after reset completes normally.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator
// Load/store initiator between the MEM pipeline stage and the data memory.
// Accepts one request at a time, rejects reserved sizes and misaligned
// accesses, issues a single strobe cycle, follows mem_clk_stall until the
// memory finishes (or gives up after STALL_TIMEOUT stalled cycles) and
// returns the result as a one-cycle response pulse.
//
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   req_*            core request, valid/ready; store data right-aligned
//   resp_*           one-cycle completion pulse; rdata/err/cause held
//   mem_addr/_write_data/_sign_mask   request lines, held between accesses
//   mem_memread/_memwrite             one-cycle access strobes
//   mem_read_data, mem_clk_stall      registered read data, busy flag
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready; checks size/alignment of an offered request
// S_ACCESS | single strobe cycle (memread or memwrite)
// S_WAIT   | strobes low, request lines held, following mem_clk_stall
// S_RESP   | resp_valid pulse; result already in the resp_* registers

module lsu_mem_initiator #(
    parameter int unsigned STALL_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_cause,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam logic [7:0] TIMEOUT_CNT       = 8'(STALL_TIMEOUT);
    localparam logic [1:0] CAUSE_SIZE        = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN_LD = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN_ST = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] stall_cnt;
    logic       write_q;
    logic       chk_err;
    logic [1:0] chk_cause;
    logic [2:0] chk_width;
    logic       timeout;

    // Size/alignment check of the offered request.
    always_comb begin
        chk_err   = 1'b0;
        chk_cause = req_write ? CAUSE_MISALIGN_ST : CAUSE_MISALIGN_LD;
        chk_width = 3'b001;
        case (req_size)
            2'b00: chk_width = 3'b001;
            2'b01: begin
                chk_width = 3'b011;
                chk_err   = req_addr[0];
            end
            2'b10: begin
                chk_width = 3'b111;
                chk_err   = |req_addr[1:0];
            end
            default: begin
                chk_err   = 1'b1;
                chk_cause = CAUSE_SIZE;
            end
        endcase
    end

    // The counter holds the number of stalled WAIT cycles already seen, so a
    // stall still present once it equals STALL_TIMEOUT gives STALL_TIMEOUT+1
    // WAIT cycles in total before the abort.
    assign timeout = mem_clk_stall && (stall_cnt == TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = chk_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_memread  = ~write_q;
                mem_memwrite = write_q;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (!mem_clk_stall || timeout) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt      <= '0;
            write_q        <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            resp_cause     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (chk_err) begin
                            resp_err   <= 1'b1;
                            resp_cause <= chk_cause;
                            resp_rdata <= '0;
                        end else begin
                            mem_addr       <= req_addr;
                            mem_write_data <= req_wdata;
                            write_q        <= req_write;
                            mem_sign_mask  <= {req_signed & ~req_write, chk_width};
                        end
                    end
                end
                S_ACCESS: stall_cnt <= '0;
                S_WAIT: begin
                    if (mem_clk_stall) begin
                        if (timeout) begin
                            resp_err   <= 1'b1;
                            resp_cause <= CAUSE_TIMEOUT;
                            resp_rdata <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                    end else begin
                        resp_err   <= 1'b0;
                        resp_cause <= '0;
                        resp_rdata <= write_q ? '0 : mem_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_cause;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.STALL_TIMEOUT(T)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_size(req_size),
        .req_signed(req_signed),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .resp_cause(resp_cause),
        .mem_addr(mem_addr),
        .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite),
        .mem_memread(mem_memread),
        .mem_sign_mask(mem_sign_mask),
        .mem_read_data(mem_read_data),
        .mem_clk_stall(mem_clk_stall)
    );

    typedef struct {
        int          resp_cyc;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
        logic        acc;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } exp_t;

    exp_t        exp_q[$];
    int          stall_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_resp_cyc = -100;
    int          strobes_seen = 0;
    logic [7:0]  ref_mem [0:1023];

    // Memory device: word array, registered read with extension, byte-lane
    // writes, busy for a per-access number of cycles after each strobe.
    logic [31:0] words [0:255];
    logic [31:0] rd_reg;
    int          stall_left;

    assign mem_read_data = rd_reg;
    assign mem_clk_stall = (stall_left != 0);

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h0123_4567;
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] w, input logic [1:0] off,
                                             input logic [3:0] m);
        logic [31:0] s;
        s = w >> (8 * off);
        case (m[2:0])
            3'b001:  return m[3] ? {{24{s[7]}}, s[7:0]} : {24'b0, s[7:0]};
            3'b011:  return m[3] ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] dev_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] off, input logic [2:0] width);
        logic [3:0]  lanes;
        logic [31:0] sd;
        logic [31:0] r;
        lanes = (width == 3'b111) ? 4'hF : (4'({1'b0, width}) << off);
        sd    = d << (8 * off);
        r     = w;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = sd[8*i +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) words[i] <= init_word(i);
            rd_reg     <= '0;
            stall_left <= 0;
        end else if (mem_memread || mem_memwrite) begin
            if (mem_memread)
                rd_reg <= dev_read(words[mem_addr[9:2]], mem_addr[1:0], mem_sign_mask);
            if (mem_memwrite)
                words[mem_addr[9:2]] <= dev_merge(words[mem_addr[9:2]], mem_write_data,
                                                  mem_addr[1:0], mem_sign_mask[2:0]);
            stall_left <= (stall_q.size() > 0) ? stall_q.pop_front() : 0;
        end else if (stall_left > 0) begin
            stall_left <= stall_left - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"},      {31'b0, req_ready},    32'd1);
        chk({tag, "_resp_valid"},     {31'b0, resp_valid},   32'd0);
        chk({tag, "_resp_err"},       {31'b0, resp_err},     32'd0);
        chk({tag, "_resp_cause"},     {30'b0, resp_cause},   32'd0);
        chk({tag, "_resp_rdata"},     resp_rdata,            32'd0);
        chk({tag, "_mem_addr"},       mem_addr,              32'd0);
        chk({tag, "_mem_write_data"}, mem_write_data,        32'd0);
        chk({tag, "_mem_memwrite"},   {31'b0, mem_memwrite}, 32'd0);
        chk({tag, "_mem_memread"},    {31'b0, mem_memread},  32'd0);
        chk({tag, "_mem_sign_mask"},  {28'b0, mem_sign_mask}, 32'd0);
    endtask

    // Monitor: checks every strobe against the pending request and every
    // response against the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                strobes_seen = 0;
            end else begin
                if (mem_memread || mem_memwrite) begin
                    strobes_seen++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL strobe_unexpected: got strobe expected none (cycle %0d)", cyc);
                    end else begin
                        e = exp_q[0];
                        chk("strobe_kind",  {31'b0, mem_memwrite}, {31'b0, e.wr});
                        chk("strobe_addr",  mem_addr, e.addr);
                        chk("strobe_mask",  {28'b0, mem_sign_mask}, {28'b0, e.mask});
                        if (e.wr) chk("strobe_wdata", mem_write_data, e.wdata);
                    end
                end
                if (resp_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL resp_unexpected: got resp_valid=1 expected none (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_cycle", cyc, e.resp_cyc);
                        chk("resp_err",   {31'b0, resp_err}, {31'b0, e.err});
                        chk("resp_rdata", resp_rdata, e.rdata);
                        if (e.err) chk("resp_cause", {30'b0, resp_cause}, {30'b0, e.cause});
                        chk("strobe_count", strobes_seen, e.acc ? 1 : 0);
                        if (e.acc) chk("held_addr", mem_addr, e.addr);
                    end
                    strobes_seen  = 0;
                    last_resp_cyc = cyc;
                end
            end
        end
    end

    // Reference model: byte-addressed memory, plain size/alignment rules and
    // latency arithmetic taken from the request and its chosen stall length.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sgn, input int stall,
                         input bit chk_b2b);
        exp_t        e;
        int          waited;
        int          nb;
        logic [31:0] v;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
        waited     = 0;
        while (req_ready !== 1'b1) begin
            @(negedge clk);
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got req_ready=0 for 50 cycles expected 1");
                req_valid = 1'b0;
                return;
            end
        end
        nb      = 1 << size;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = '0;
        e.err   = 1'b0;
        e.cause = 2'd0;
        e.acc   = 1'b1;
        case (size)
            2'd0:    e.mask = {sgn & ~wr, 3'b001};
            2'd1:    e.mask = {sgn & ~wr, 3'b011};
            default: e.mask = {sgn & ~wr, 3'b111};
        endcase
        if (size == 2'd3) begin
            e.err   = 1'b1;
            e.cause = 2'd0;
        end else if (addr % nb != 0) begin
            e.err   = 1'b1;
            e.cause = wr ? 2'd2 : 2'd1;
        end
        if (e.err) begin
            e.acc      = 1'b0;
            e.resp_cyc = cyc + 1;
        end else begin
            if (wr) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(addr[9:0]) + i] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v |= 32'(ref_mem[int'(addr[9:0]) + i]) << (8 * i);
                if (sgn && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
                e.rdata = v;
            end
            if (stall > T) begin
                e.err      = 1'b1;
                e.cause    = 2'd3;
                e.rdata    = '0;
                e.resp_cyc = cyc + T + 3;
            end else begin
                e.resp_cyc = cyc + 3 + stall;
            end
            stall_q.push_back(stall);
        end
        if (chk_b2b && waited > 0) chk("b2b_accept_cycle", cyc, last_resp_cyc + 1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: got no end of test expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : main
        logic [31:0] a;
        logic [31:0] w;
        logic        wr;
        logic        sgn;
        logic [1:0]  size;
        int          r;
        int          lo;
        int          st;

        for (int i = 0; i < 256; i++) begin
            w = init_word(i);
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_size   = '0;
        req_signed = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Word load of 0xDEADBEEF (written first through a store).
        issue(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, 1, 1'b0);
        issue(1'b0, 32'h100, 32'h0,         2'd2, 1'b0, 0, 1'b1);
        // Signed byte load at 0x103 of word 0x80FF_0000.
        issue(1'b1, 32'h100, 32'h80FF_0000, 2'd2, 1'b0, 1, 1'b1);
        issue(1'b0, 32'h103, 32'h0,         2'd0, 1'b1, 0, 1'b1);
        // Halfword store into 0xAAAABBBB, then word load.
        issue(1'b1, 32'h100, 32'hAAAA_BBBB, 2'd2, 1'b0, 1, 1'b1);
        issue(1'b1, 32'h102, 32'h0000_1234, 2'd1, 1'b0, 1, 1'b1);
        issue(1'b0, 32'h100, 32'h0,         2'd2, 1'b0, 0, 1'b1);
        // Error cases.
        issue(1'b0, 32'h101, 32'h0,         2'd2, 1'b0, 0, 1'b1);
        issue(1'b1, 32'h203, 32'h5555,      2'd1, 1'b0, 0, 1'b1);
        issue(1'b0, 32'h204, 32'h0,         2'd3, 1'b0, 0, 1'b1);
        // Stall exactly at the limit, then past it (timeout), then a load
        // accepted the cycle after the timeout response.
        issue(1'b1, 32'h208, 32'h1111_2222, 2'd2, 1'b0, T, 1'b1);
        issue(1'b1, 32'h20C, 32'h3333_4444, 2'd2, 1'b0, T + 2, 1'b1);
        issue(1'b0, 32'h20C, 32'h0,         2'd2, 1'b0, 0, 1'b1);
        drain();

        // Reset while a store is in WAIT, with a request offered at the
        // reset edge.
        issue(1'b1, 32'h300, 32'hCAFE_F00D, 2'd2, 1'b0, T + 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h300;
        req_size   = 2'd2;
        @(negedge clk);
        check_reset_vals("midreset");
        exp_q.delete();
        stall_q.delete();
        req_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (6) @(negedge clk);
        chk("midreset_no_resp", {31'b0, resp_valid}, 32'd0);
        issue(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 0, 1'b0);
        drain();

        // Randomized traffic.
        for (int k = 0; k < 150; k++) begin
            wr  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            lo  = $urandom_range(0, 1023);
            if ($urandom_range(0, 7) != 0) begin
                if (size == 2'd1) lo = lo & ~1;
                if (size == 2'd2) lo = lo & ~3;
            end
            a = $urandom();
            a = {a[31:10], 10'(lo)};
            w = $urandom();
            if (wr) st = $urandom_range(1, T + 2);
            else    st = ($urandom_range(0, 4) == 0) ? $urandom_range(1, T + 1) : 0;
            issue(wr, a, w, size, sgn, st, 1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
